rv_hazard_ctrl: RTL and testbench

RV_HAZARD_CTRL -- requirements
Module: rv_hazard_ctrl

---
 rtl/rv_hazard_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_rv_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : rv_hazard_ctrl
// Description : Pipeline hazard controller for a 5-stage RISC-V core.
//               Provides combinational operand forwarding selects and
//               stall/flush controls for load-use hazards (LOAD_LAT cycles),
//               multi-cycle multiply/divide waits and taken branches.
//               Optional macro RV_HAZARD_PERF_EN enables the saturating
//               StallCnt hazard-cycle counter; without it StallCnt is 0.
//               LOAD_LAT legal range is 1..4.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rv_hazard_ctrl #(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] Rs1D,
  input  logic [AW-1:0] Rs2D,
  input  logic [AW-1:0] Rs1E,
  input  logic [AW-1:0] Rs2E,
  input  logic [AW-1:0] RdE,
  input  logic [AW-1:0] RdM,
  input  logic [AW-1:0] RdW,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          LoadE,
  input  logic          PCSrcE,
  input  logic          MduStartE,
  input  logic          MduDone,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          FlushD,
  output logic          FlushE,
  output logic          FlushM,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic [31:0]   StallCnt
);

  // FSM encoding
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LDSTALL = 2'd1;
  localparam logic [1:0] ST_MDUWAIT = 2'd2;

  // Forwarding select encoding
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Extra load-stall cycles spent in LDSTALL after the initial RUN stall cycle
  localparam logic [2:0] LAT_RELOAD = 3'(LOAD_LAT - 1);
  localparam bit         MULTI_LAT  = (LOAD_LAT > 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [2:0] ld_cnt;
  logic [2:0] ld_cnt_nxt;
  logic       load_use;
  logic       mdu_begin;
  logic       m_wr_valid;
  logic       w_wr_valid;

  // Hazard detection terms; a destination of x0 never matches anything
  assign load_use   = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mdu_begin  = MduStartE && !MduDone;
  assign m_wr_valid = RegWriteM && (RdM != '0);
  assign w_wr_valid = RegWriteW && (RdW != '0);

  // Forwarding selects: memory stage has priority over writeback
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (m_wr_valid && (RdM == Rs1E)) begin
      ForwardAE = FWD_MEM;
    end else if (w_wr_valid && (RdW == Rs1E)) begin
      ForwardAE = FWD_WB;
    end
    if (m_wr_valid && (RdM == Rs2E)) begin
      ForwardBE = FWD_MEM;
    end else if (w_wr_valid && (RdW == Rs2E)) begin
      ForwardBE = FWD_WB;
    end
  end

  // State and load-stall counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_RUN;
      ld_cnt <= 3'd0;
    end else begin
      state  <= state_nxt;
      ld_cnt <= ld_cnt_nxt;
    end
  end

  // Next-state logic; a taken branch wins over any new hazard in RUN
  always_comb begin
    state_nxt  = state;
    ld_cnt_nxt = ld_cnt;
    case (state)
      ST_RUN: begin
        if (PCSrcE) begin
          state_nxt = ST_RUN;
        end else if (mdu_begin) begin
          state_nxt = ST_MDUWAIT;
        end else if (load_use && MULTI_LAT) begin
          state_nxt  = ST_LDSTALL;
          ld_cnt_nxt = LAT_RELOAD;
        end
      end
      ST_LDSTALL: begin
        // Leave when this is the last stall cycle or a branch aborts the stall
        if (PCSrcE || (ld_cnt <= 3'd1)) begin
          state_nxt  = ST_RUN;
          ld_cnt_nxt = 3'd0;
        end else begin
          ld_cnt_nxt = ld_cnt - 3'd1;
        end
      end
      ST_MDUWAIT: begin
        // A branch cannot legally resolve while E is held, so PCSrcE is ignored
        if (MduDone) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt  = ST_RUN;
        ld_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Stall/flush outputs, zero-latency from state and inputs, forced low in reset
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (mdu_begin) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
          end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        ST_LDSTALL: begin
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        ST_MDUWAIT: begin
          if (!MduDone) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
          end
        end
        default: begin
          StallF = 1'b0;
        end
      endcase
    end
  end

`ifdef RV_HAZARD_PERF_EN
  // Saturating count of cycles in which fetch is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCnt <= 32'd0;
    end else if (StallF && (StallCnt != 32'hFFFF_FFFF)) begin
      StallCnt <= StallCnt + 32'd1;
    end
  end
`else
  assign StallCnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_rv_hazard_ctrl
// Description : Directed self-checking bench for rv_hazard_ctrl. Two
//               instances (LOAD_LAT=1 and LOAD_LAT=3) share all inputs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rv_hazard_ctrl;

`ifdef RV_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MduStartE, MduDone;

  logic        a_stall_f, a_stall_d, a_stall_e, a_flush_d, a_flush_e, a_flush_m;
  logic [1:0]  a_fwd_a, a_fwd_b;
  logic [31:0] a_cnt;
  logic        b_stall_f, b_stall_d, b_stall_e, b_flush_d, b_flush_e, b_flush_m;
  logic [1:0]  b_fwd_a, b_fwd_b;
  logic [31:0] b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_hazard_ctrl #(.AW(5), .LOAD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE),
    .PCSrcE(PCSrcE), .MduStartE(MduStartE), .MduDone(MduDone),
    .StallF(a_stall_f), .StallD(a_stall_d), .StallE(a_stall_e),
    .FlushD(a_flush_d), .FlushE(a_flush_e), .FlushM(a_flush_m),
    .ForwardAE(a_fwd_a), .ForwardBE(a_fwd_b), .StallCnt(a_cnt)
  );

  rv_hazard_ctrl #(.AW(5), .LOAD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE),
    .PCSrcE(PCSrcE), .MduStartE(MduStartE), .MduDone(MduDone),
    .StallF(b_stall_f), .StallD(b_stall_d), .StallE(b_stall_e),
    .FlushD(b_flush_d), .FlushE(b_flush_e), .FlushM(b_flush_m),
    .ForwardAE(b_fwd_a), .ForwardBE(b_fwd_b), .StallCnt(b_cnt)
  );

  // Packed views: {StallF, StallD, StallE, FlushD, FlushE, FlushM}
  wire [5:0] a_ctl = {a_stall_f, a_stall_d, a_stall_e, a_flush_d, a_flush_e, a_flush_m};
  wire [5:0] b_ctl = {b_stall_f, b_stall_d, b_stall_e, b_flush_d, b_flush_e, b_flush_m};

  localparam logic [5:0] CTL_NONE = 6'b000000;
  localparam logic [5:0] CTL_LD   = 6'b110010;
  localparam logic [5:0] CTL_MDU  = 6'b111001;
  localparam logic [5:0] CTL_BR   = 6'b000110;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0;
    PCSrcE = 1'b0; MduStartE = 1'b0; MduDone = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1);
    LoadE = 1'b1; RdE = rd; Rs1D = rs1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;

    // Reset: stalls suppressed even with a live load-use; forwarding follows inputs
    set_load_use(5'd5, 5'd5);
    RegWriteM = 1'b1; RdM = 5'd7; Rs1E = 5'd7;
    #1;
    check("rst_ctl_lat1", {26'd0, a_ctl}, {26'd0, CTL_NONE});
    check("rst_ctl_lat3", {26'd0, b_ctl}, {26'd0, CTL_NONE});
    check("rst_cnt", a_cnt, 32'd0);
    check("rst_fwd_a", {30'd0, a_fwd_a}, 32'd2);
    tick();
    do_reset();

    // Forwarding
    RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; Rs2E = 5'd7;
    #1;
    check("fwd_mem_prio_a", {30'd0, a_fwd_a}, 32'd2);
    check("fwd_mem_prio_b", {30'd0, a_fwd_b}, 32'd2);
    RdM = 5'd3;
    #1;
    check("fwd_wb_a", {30'd0, a_fwd_a}, 32'd1);
    RegWriteW = 1'b0;
    #1;
    check("fwd_none_a", {30'd0, a_fwd_a}, 32'd0);
    RdM = 5'd0; Rs2E = 5'd0; RegWriteW = 1'b1; RdW = 5'd0;
    #1;
    check("fwd_x0_b", {30'd0, a_fwd_b}, 32'd0);
    clear_inputs();

    // x0 destination never stalls
    set_load_use(5'd0, 5'd0);
    #1;
    check("ld_x0_nostall", {26'd0, a_ctl}, {26'd0, CTL_NONE});
    clear_inputs();

    // Load-use, LOAD_LAT=1: one stall cycle (also via Rs2D)
    LoadE = 1'b1; RdE = 5'd5; Rs2D = 5'd5;
    #1;
    check("lu1_c0", {26'd0, a_ctl}, {26'd0, CTL_LD});
    tick();
    clear_inputs();
    #1;
    check("lu1_c1", {26'd0, a_ctl}, {26'd0, CTL_NONE});
    check("lu1_cnt", a_cnt, PERF ? 32'd1 : 32'd0);

    // Load-use, LOAD_LAT=3: exactly three stall cycles
    do_reset();
    set_load_use(5'd5, 5'd5);
    #1;
    check("lu3_c0", {26'd0, b_ctl}, {26'd0, CTL_LD});
    tick();
    clear_inputs();
    #1;
    check("lu3_c1", {26'd0, b_ctl}, {26'd0, CTL_LD});
    tick();
    check("lu3_c2", {26'd0, b_ctl}, {26'd0, CTL_LD});
    tick();
    check("lu3_c3", {26'd0, b_ctl}, {26'd0, CTL_NONE});
    check("lu3_cnt", b_cnt, PERF ? 32'd3 : 32'd0);
    tick();
    check("lu3_cnt_hold", b_cnt, PERF ? 32'd3 : 32'd0);

    // MDU wait: five stall cycles, released in the MduDone cycle
    do_reset();
    MduStartE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) PCSrcE = 1'b1;  // ignored while waiting
      #1;
      check($sformatf("mdu_c%0d", i), {26'd0, a_ctl}, {26'd0, CTL_MDU});
      PCSrcE = 1'b0;
      tick();
    end
    MduDone = 1'b1;
    #1;
    check("mdu_done", {26'd0, a_ctl}, {26'd0, CTL_NONE});
    tick();
    clear_inputs();
    #1;
    check("mdu_after", {26'd0, a_ctl}, {26'd0, CTL_NONE});
    check("mdu_cnt", a_cnt, PERF ? 32'd5 : 32'd0);

    // MduStartE with MduDone in the same cycle: no stall, stays in RUN
    do_reset();
    MduStartE = 1'b1; MduDone = 1'b1;
    #1;
    check("mdu_same", {26'd0, a_ctl}, {26'd0, CTL_NONE});
    tick();
    clear_inputs();
    #1;
    check("mdu_same_next", {26'd0, a_ctl}, {26'd0, CTL_NONE});

    // Load-use together with a taken branch: branch wins
    do_reset();
    set_load_use(5'd5, 5'd5);
    PCSrcE = 1'b1;
    #1;
    check("lu_br_same", {26'd0, b_ctl}, {26'd0, CTL_BR});
    tick();
    clear_inputs();
    #1;
    check("lu_br_next", {26'd0, b_ctl}, {26'd0, CTL_NONE});

    // Branch aborts LDSTALL (LOAD_LAT=3) at stall cycle 2
    do_reset();
    set_load_use(5'd9, 5'd9);
    #1;
    check("abort_c0", {26'd0, b_ctl}, {26'd0, CTL_LD});
    tick();
    clear_inputs();
    PCSrcE = 1'b1;
    #1;
    check("abort_c1", {26'd0, b_ctl}, {26'd0, CTL_BR});
    tick();
    PCSrcE = 1'b0;
    #1;
    check("abort_run", {26'd0, b_ctl}, {26'd0, CTL_NONE});

    // Reset asserted during MDU wait cycle 2
    do_reset();
    MduStartE = 1'b1;
    tick();
    tick();
    check("rstmdu_pre", {26'd0, a_ctl}, {26'd0, CTL_MDU});
    reset = 1'b1;
    #1;
    check("rstmdu_ctl", {26'd0, a_ctl}, {26'd0, CTL_NONE});
    check("rstmdu_cnt", a_cnt, 32'd0);
    clear_inputs();
    #1;
    reset = 1'b0;
    tick();
    check("rstmdu_run", {26'd0, a_ctl}, {26'd0, CTL_NONE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
